fib_lookup_arbiter: RTL and testbench

Shares the single FIB lookup port between the two NDN router requesters: outgoing interests from the PIT and incoming data packets. Grants one request at a time with round-robin fairness and issues a one-cycle FIB start. It then waits for completion, re-issues lookups the PIT rejects (bounded), and aborts lookups that exceed a timeout. It sits between the PIT/data ingress logic and the `fib` block.

---
 rtl/fib_pkg.sv | 48 ++++
 rtl/fib_lookup_arbiter_rr_arb2.sv | 36 +++
 rtl/fib_lookup_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_fib_lookup_arbiter.sv | 423 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fib_pkg.sv
// fib_pkg: definitions shared by the FIB lookup path (the arbiter, the fib
// block and its PIT-side logic).
//   - default prefix and prefix-length widths
//   - direction encoding (outgoing interest / incoming data)
//   - lookup-arbiter state encoding and result record
//   - rr_pick: two-requester round-robin choice
package fib_pkg;

    localparam int PREFIX_W_DEF = 64;
    localparam int LEN_W_DEF    = 6;

    localparam logic DIR_OUT = 1'b0;
    localparam logic DIR_IN  = 1'b1;

    localparam logic [1:0] ST_IDLE_ENC  = 2'd0;
    localparam logic [1:0] ST_ISSUE_ENC = 2'd1;
    localparam logic [1:0] ST_WAIT_ENC  = 2'd2;
    localparam logic [1:0] ST_DONE_ENC  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = ST_IDLE_ENC,
        ST_ISSUE = ST_ISSUE_ENC,
        ST_WAIT  = ST_WAIT_ENC,
        ST_DONE  = ST_DONE_ENC
    } state_t;

    typedef struct packed {
        logic dir;
        logic ok;
        logic timeout;
    } res_t;

    // On contention the direction that was not served last wins; a lone
    // requester always wins.
    function automatic logic rr_pick(input logic req_out, input logic req_in,
                                     input logic last_dir);
        logic dir;
        if (req_out && req_in) begin
            dir = ~last_dir;
        end else if (req_in) begin
            dir = DIR_IN;
        end else begin
            dir = DIR_OUT;
        end
        return dir;
    endfunction

endpackage

// File: rtl/fib_lookup_arbiter_rr_arb2.sv
// rr_arb2: two-requester round-robin picker.
// Ports:
//   i_clk, i_rst_n        clock, async active-low reset
//   i_req_out, i_req_in   requests from outgoing / incoming side
//   i_update              commit the current pick as the last served direction
//   o_gnt_valid           at least one request present
//   o_gnt_dir             picked direction (DIR_OUT / DIR_IN)
module rr_arb2
    import fib_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_req_out,
    input  logic i_req_in,
    input  logic i_update,
    output logic o_gnt_valid,
    output logic o_gnt_dir
);

    logic r_last_dir;
    logic w_pick;

    assign w_pick      = rr_pick(i_req_out, i_req_in, r_last_dir);
    assign o_gnt_valid = i_req_out | i_req_in;
    assign o_gnt_dir   = w_pick;

    // Resetting to DIR_IN makes the outgoing side win the first contention.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_last_dir <= DIR_IN;
        end else if (i_update) begin
            r_last_dir <= w_pick;
        end
    end

endmodule

// File: rtl/fib_lookup_arbiter.sv
// fib_lookup_arbiter: shares the single FIB lookup port between the PIT
// (outgoing interests) and data ingress (incoming data).
//
// state | meaning
// IDLE  | no lookup in flight, arbitrate and capture a request
// ISSUE | fib_start pulse (plus ack for a fresh grant)
// WAIT  | waiting for fib_done; retry on rejection, abort on timeout
// DONE  | one-cycle result pulse
//
// Ports:
//   i_clk, i_rst_n                       clock, async active-low reset
//   i_out_req/i_out_prefix/i_out_len     outgoing request, held until o_out_ack
//   i_in_req/i_in_prefix/i_in_len        incoming request, held until o_in_ack
//   o_out_ack, o_in_ack                  one-cycle capture pulses
//   o_fib_start                          one-cycle lookup start
//   o_fib_prefix/o_fib_len/o_fib_dir     captured request, stable ISSUE..IDLE
//   i_fib_done, i_fib_rejected           lookup completion (WAIT only)
//   o_res_valid/o_res_dir/o_res_ok/o_res_timeout  one-cycle result, 0 otherwise
module fib_lookup_arbiter
    import fib_pkg::*;
#(
    parameter int PREFIX_W  = PREFIX_W_DEF,
    parameter int LEN_W     = LEN_W_DEF,
    parameter int TIMEOUT   = 64,
    parameter int MAX_RETRY = 3
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_out_req,
    input  logic [PREFIX_W-1:0] i_out_prefix,
    input  logic [LEN_W-1:0]    i_out_len,
    output logic                o_out_ack,
    input  logic                i_in_req,
    input  logic [PREFIX_W-1:0] i_in_prefix,
    input  logic [LEN_W-1:0]    i_in_len,
    output logic                o_in_ack,
    output logic                o_fib_start,
    output logic [PREFIX_W-1:0] o_fib_prefix,
    output logic [LEN_W-1:0]    o_fib_len,
    output logic                o_fib_dir,
    input  logic                i_fib_done,
    input  logic                i_fib_rejected,
    output logic                o_res_valid,
    output logic                o_res_dir,
    output logic                o_res_ok,
    output logic                o_res_timeout
);

    localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int RW = $clog2(MAX_RETRY + 1);
    localparam logic [WW-1:0] WAIT_LAST  = WW'(TIMEOUT - 1);
    localparam logic [RW-1:0] RETRY_LAST = RW'(MAX_RETRY);

    state_t              r_state;
    logic [PREFIX_W-1:0] r_prefix;
    logic [LEN_W-1:0]    r_len;
    logic                r_dir;
    logic [RW-1:0]       r_retry;
    logic [WW-1:0]       r_wait;
    logic                r_wait_first;
    logic                r_fib_start;
    logic                r_out_ack;
    logic                r_in_ack;
    logic                r_res_valid;
    res_t                r_res;

    logic w_gnt_valid;
    logic w_gnt_dir;
    logic w_arb_upd;

    assign w_arb_upd = (r_state == ST_IDLE) && w_gnt_valid;

    rr_arb2 u_rr_arb2 (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_req_out   (i_out_req),
        .i_req_in    (i_in_req),
        .i_update    (w_arb_upd),
        .o_gnt_valid (w_gnt_valid),
        .o_gnt_dir   (w_gnt_dir)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= ST_IDLE;
            r_prefix     <= '0;
            r_len        <= '0;
            r_dir        <= DIR_OUT;
            r_retry      <= '0;
            r_wait       <= '0;
            r_wait_first <= 1'b0;
            r_fib_start  <= 1'b0;
            r_out_ack    <= 1'b0;
            r_in_ack     <= 1'b0;
            r_res_valid  <= 1'b0;
            r_res        <= '0;
        end else begin
            // Pulse outputs default low; the branches below raise them.
            r_fib_start <= 1'b0;
            r_out_ack   <= 1'b0;
            r_in_ack    <= 1'b0;
            r_res_valid <= 1'b0;
            r_res       <= '0;

            case (r_state)
                ST_IDLE: begin
                    if (w_gnt_valid) begin
                        r_dir        <= w_gnt_dir;
                        r_prefix     <= (w_gnt_dir == DIR_IN) ? i_in_prefix : i_out_prefix;
                        r_len        <= (w_gnt_dir == DIR_IN) ? i_in_len : i_out_len;
                        r_retry      <= '0;
                        r_wait       <= '0;
                        r_wait_first <= 1'b1;
                        r_fib_start  <= 1'b1;
                        r_out_ack    <= (w_gnt_dir == DIR_OUT);
                        r_in_ack     <= (w_gnt_dir == DIR_IN);
                        r_state      <= ST_ISSUE;
                    end
                end

                ST_ISSUE: begin
                    r_wait       <= '0;
                    r_wait_first <= 1'b1;
                    r_state      <= ST_WAIT;
                end

                ST_WAIT: begin
                    // The first WAIT cycle is the FIB's launch cycle and is
                    // not counted, so an abort lands TIMEOUT+2 cycles after
                    // fib_start. The counter saturates rather than wrapping.
                    if (r_wait_first) begin
                        r_wait_first <= 1'b0;
                    end else if (r_wait != WAIT_LAST) begin
                        r_wait <= r_wait + 1'b1;
                    end

                    // fib_done is checked first so it wins over the timeout.
                    if (i_fib_done) begin
                        if (!i_fib_rejected) begin
                            r_res_valid <= 1'b1;
                            r_res       <= '{dir: r_dir, ok: 1'b1, timeout: 1'b0};
                            r_state     <= ST_DONE;
                        end else if (r_retry < RETRY_LAST) begin
                            r_retry     <= r_retry + 1'b1;
                            r_wait      <= '0;
                            r_fib_start <= 1'b1;
                            r_state     <= ST_ISSUE;
                        end else begin
                            r_res_valid <= 1'b1;
                            r_res       <= '{dir: r_dir, ok: 1'b0, timeout: 1'b0};
                            r_state     <= ST_DONE;
                        end
                    end else if (!r_wait_first && (r_wait == WAIT_LAST)) begin
                        r_res_valid <= 1'b1;
                        r_res       <= '{dir: r_dir, ok: 1'b0, timeout: 1'b1};
                        r_state     <= ST_DONE;
                    end
                end

                ST_DONE: begin
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_out_ack     = r_out_ack;
    assign o_in_ack      = r_in_ack;
    assign o_fib_start   = r_fib_start;
    assign o_fib_prefix  = r_prefix;
    assign o_fib_len     = r_len;
    assign o_fib_dir     = r_dir;
    assign o_res_valid   = r_res_valid;
    assign o_res_dir     = r_res.dir;
    assign o_res_ok      = r_res.ok;
    assign o_res_timeout = r_res.timeout;

endmodule

// File: tb/tb_fib_lookup_arbiter.sv
module tb_fib_lookup_arbiter;
    import fib_pkg::*;

    localparam int PW  = 64;
    localparam int LW  = 6;
    localparam int TMO = 64;
    localparam int MR  = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          out_req = 1'b0;
    logic [PW-1:0] out_prefix = '0;
    logic [LW-1:0] out_len = '0;
    logic          out_ack;
    logic          in_req = 1'b0;
    logic [PW-1:0] in_prefix = '0;
    logic [LW-1:0] in_len = '0;
    logic          in_ack;
    logic          fib_start;
    logic [PW-1:0] fib_prefix;
    logic [LW-1:0] fib_len;
    logic          fib_dir;
    logic          fib_done = 1'b0;
    logic          fib_rejected = 1'b0;
    logic          res_valid;
    logic          res_dir;
    logic          res_ok;
    logic          res_timeout;

    always #5 clk = ~clk;

    fib_lookup_arbiter #(
        .PREFIX_W  (PW),
        .LEN_W     (LW),
        .TIMEOUT   (TMO),
        .MAX_RETRY (MR)
    ) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_out_req      (out_req),
        .i_out_prefix   (out_prefix),
        .i_out_len      (out_len),
        .o_out_ack      (out_ack),
        .i_in_req       (in_req),
        .i_in_prefix    (in_prefix),
        .i_in_len       (in_len),
        .o_in_ack       (in_ack),
        .o_fib_start    (fib_start),
        .o_fib_prefix   (fib_prefix),
        .o_fib_len      (fib_len),
        .o_fib_dir      (fib_dir),
        .i_fib_done     (fib_done),
        .i_fib_rejected (fib_rejected),
        .o_res_valid    (res_valid),
        .o_res_dir      (res_dir),
        .o_res_ok       (res_ok),
        .o_res_timeout  (res_timeout)
    );

    int total = 0;
    int bad = 0;
    int start_cnt = 0;
    int ack_cnt = 0;
    int res_cnt = 0;
    logic [2:0] sb[$];
    logic [2:0] exp_r;

    // Scoreboard: each result pulse is compared with the oldest expectation
    // ({dir, ok, timeout}) pushed when the request was granted.
    always @(negedge clk) begin
        if (fib_start === 1'b1) start_cnt++;
        if (out_ack === 1'b1 || in_ack === 1'b1) ack_cnt++;
        if (res_valid === 1'b1) begin
            res_cnt++;
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected_result: got dir=%0b ok=%0b to=%0b, required no result",
                         res_dir, res_ok, res_timeout);
            end else begin
                exp_r = sb.pop_front();
                if ({res_dir, res_ok, res_timeout} !== exp_r) begin
                    bad++;
                    $display("FAIL sb_result: got dir/ok/to=%03b, required %03b",
                             {res_dir, res_ok, res_timeout}, exp_r);
                end
            end
        end
    end

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_ack(input int budget, output int n);
        n = 0;
        while (!(out_ack === 1'b1 || in_ack === 1'b1) && n < budget) begin
            cyc();
            n++;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) cyc();
        total++;
        if ({out_ack, in_ack, fib_start, fib_dir, res_valid, res_dir, res_ok, res_timeout} !== 8'h00) begin
            bad++;
            $display("FAIL reset_ctrl: got %08b, required 00000000",
                     {out_ack, in_ack, fib_start, fib_dir, res_valid, res_dir, res_ok, res_timeout});
        end
        total++;
        if (fib_prefix !== '0 || fib_len !== '0) begin
            bad++;
            $display("FAIL reset_data: got prefix=%h len=%0d, required 0", fib_prefix, fib_len);
        end
        rst_n = 1'b1;
        cyc();
        cyc();
        total++;
        if (start_cnt != 0 || fib_start !== 1'b0) begin
            bad++;
            $display("FAIL idle_quiet: got starts=%0d, required 0", start_cnt);
        end
    endtask

    task automatic test_single_out();
        int n;
        out_prefix = 64'h0000FFFF0000FFFF;
        out_len    = 6'd10;
        out_req    = 1'b1;
        wait_ack(8, n);
        total++;
        if (n != 1 || out_ack !== 1'b1 || in_ack !== 1'b0 || fib_start !== 1'b1 || fib_dir !== DIR_OUT) begin
            bad++;
            $display("FAIL single_grant: got lat=%0d oack=%0b iack=%0b start=%0b dir=%0b, required 1 1 0 1 0",
                     n, out_ack, in_ack, fib_start, fib_dir);
        end
        total++;
        if (fib_prefix !== 64'h0000FFFF0000FFFF || fib_len !== 6'd10) begin
            bad++;
            $display("FAIL single_capture: got prefix=%h len=%0d, required 0000ffff0000ffff 10",
                     fib_prefix, fib_len);
        end
        sb.push_back({DIR_OUT, 1'b1, 1'b0});
        out_req = 1'b0;
        cyc();
        fib_done = 1'b1;
        cyc();
        fib_done = 1'b0;
        total++;
        if (res_valid !== 1'b1) begin
            bad++;
            $display("FAIL single_result: got res_valid=%0b, required 1", res_valid);
        end
        cyc();
        total++;
        if ({res_valid, res_dir, res_ok, res_timeout} !== 4'b0000) begin
            bad++;
            $display("FAIL res_cleared: got %04b, required 0000", {res_valid, res_dir, res_ok, res_timeout});
        end
    endtask

    task automatic test_back_to_back();
        int n;
        int a0;
        logic exp_dir;
        do_reset();
        out_prefix = 64'h1111_2222_3333_4444;
        in_prefix  = 64'hAAAA_BBBB_CCCC_DDDD;
        out_len    = 6'd20;
        in_len     = 6'd33;
        out_req    = 1'b1;
        in_req     = 1'b1;
        exp_dir    = DIR_OUT;
        a0         = ack_cnt;
        for (int k = 0; k < 4; k++) begin
            wait_ack(8, n);
            total++;
            if (fib_dir !== exp_dir || out_ack !== (exp_dir == DIR_OUT) || in_ack !== (exp_dir == DIR_IN)) begin
                bad++;
                $display("FAIL rr_order[%0d]: got dir=%0b oack=%0b iack=%0b, required dir=%0b",
                         k, fib_dir, out_ack, in_ack, exp_dir);
            end
            total++;
            if (fib_prefix !== ((exp_dir == DIR_IN) ? in_prefix : out_prefix) ||
                fib_len !== ((exp_dir == DIR_IN) ? in_len : out_len)) begin
                bad++;
                $display("FAIL rr_capture[%0d]: got prefix=%h len=%0d", k, fib_prefix, fib_len);
            end
            if (k > 0) begin
                total++;
                if (n != 2) begin
                    bad++;
                    $display("FAIL turnaround[%0d]: got %0d cycles result-to-ack, required 2", k, n);
                end
            end
            sb.push_back({exp_dir, 1'b1, 1'b0});
            cyc();
            fib_done = 1'b1;
            cyc();
            fib_done = 1'b0;
            total++;
            if (res_valid !== 1'b1) begin
                bad++;
                $display("FAIL rr_result[%0d]: got res_valid=%0b, required 1", k, res_valid);
            end
            exp_dir = ~exp_dir;
        end
        out_req = 1'b0;
        in_req  = 1'b0;
        total++;
        if (ack_cnt - a0 != 4) begin
            bad++;
            $display("FAIL rr_ack_count: got %0d, required 4", ack_cnt - a0);
        end
        cyc();
        cyc();
    endtask

    task automatic test_retry();
        int n;
        int s0;
        int a0;
        out_req = 1'b1;
        wait_ack(8, n);
        total++;
        if (out_ack !== 1'b1) begin
            bad++;
            $display("FAIL retry_grant: got oack=%0b, required 1", out_ack);
        end
        s0 = start_cnt;
        a0 = ack_cnt;
        out_req = 1'b0;
        sb.push_back({DIR_OUT, 1'b0, 1'b0});
        for (int a = 0; a <= MR; a++) begin
            cyc();
            fib_done     = 1'b1;
            fib_rejected = 1'b1;
            cyc();
            fib_done     = 1'b0;
            fib_rejected = 1'b0;
            total++;
            if (a < MR) begin
                if (fib_start !== 1'b1 || out_ack !== 1'b0 || res_valid !== 1'b0) begin
                    bad++;
                    $display("FAIL retry_reissue[%0d]: got start=%0b oack=%0b rv=%0b, required 1 0 0",
                             a, fib_start, out_ack, res_valid);
                end
            end else if (res_valid !== 1'b1) begin
                bad++;
                $display("FAIL retry_final: got res_valid=%0b, required 1", res_valid);
            end
        end
        total++;
        if (start_cnt - s0 + 1 != MR + 1) begin
            bad++;
            $display("FAIL retry_starts: got %0d fib_start pulses, required %0d", start_cnt - s0 + 1, MR + 1);
        end
        total++;
        if (ack_cnt != a0) begin
            bad++;
            $display("FAIL retry_no_ack: got %0d extra acks, required 0", ack_cnt - a0);
        end
        cyc();
    endtask

    task automatic test_timeout();
        int n;
        in_prefix = 64'hDEAD_BEEF_0000_0001;
        in_len    = 6'd48;
        in_req    = 1'b1;
        wait_ack(8, n);
        in_req = 1'b0;
        total++;
        if (in_ack !== 1'b1 || fib_start !== 1'b1) begin
            bad++;
            $display("FAIL timeout_grant: got iack=%0b start=%0b, required 1 1", in_ack, fib_start);
        end
        sb.push_back({DIR_IN, 1'b0, 1'b1});
        n = 0;
        while (res_valid !== 1'b1 && n < 200) begin
            cyc();
            n++;
        end
        total++;
        if (n != TMO + 2) begin
            bad++;
            $display("FAIL timeout_latency: got %0d cycles start-to-result, required %0d", n, TMO + 2);
        end
        out_req = 1'b1;
        wait_ack(8, n);
        out_req = 1'b0;
        total++;
        if (out_ack !== 1'b1 || n != 2) begin
            bad++;
            $display("FAIL after_timeout_grant: got oack=%0b lat=%0d, required 1 2", out_ack, n);
        end
        sb.push_back({DIR_OUT, 1'b1, 1'b0});
        cyc();
        fib_done = 1'b1;
        cyc();
        fib_done = 1'b0;
        total++;
        if (res_valid !== 1'b1) begin
            bad++;
            $display("FAIL after_timeout_result: got res_valid=%0b, required 1", res_valid);
        end
        cyc();
    endtask

    task automatic test_done_at_timeout();
        int n;
        out_req = 1'b1;
        wait_ack(8, n);
        out_req = 1'b0;
        sb.push_back({DIR_OUT, 1'b1, 1'b0});
        repeat (TMO + 1) cyc();
        total++;
        if (res_valid !== 1'b0) begin
            bad++;
            $display("FAIL early_timeout: got res_valid=%0b on last wait cycle, required 0", res_valid);
        end
        fib_done = 1'b1;
        cyc();
        fib_done = 1'b0;
        total++;
        if (res_valid !== 1'b1 || res_ok !== 1'b1 || res_timeout !== 1'b0) begin
            bad++;
            $display("FAIL done_wins: got rv=%0b ok=%0b to=%0b, required 1 1 0", res_valid, res_ok, res_timeout);
        end
        cyc();
    endtask

    task automatic test_reset_mid_wait();
        int n;
        int rc0;
        in_prefix = 64'h0123_4567_89AB_CDEF;
        in_len    = 6'd63;
        in_req    = 1'b1;
        wait_ack(8, n);
        in_req = 1'b0;
        cyc();
        cyc();
        in_req = 1'b1;
        total++;
        if (fib_dir !== DIR_IN || fib_prefix !== 64'h0123_4567_89AB_CDEF) begin
            bad++;
            $display("FAIL pre_reset_state: got dir=%0b prefix=%h", fib_dir, fib_prefix);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if ({out_ack, in_ack, fib_start, fib_dir, res_valid, res_dir, res_ok, res_timeout} !== 8'h00 ||
            fib_prefix !== '0 || fib_len !== '0) begin
            bad++;
            $display("FAIL async_reset: got ctrl=%08b prefix=%h len=%0d, required all 0",
                     {out_ack, in_ack, fib_start, fib_dir, res_valid, res_dir, res_ok, res_timeout},
                     fib_prefix, fib_len);
        end
        cyc();
        cyc();
        rc0 = res_cnt;
        rst_n = 1'b1;
        wait_ack(8, n);
        total++;
        if (in_ack !== 1'b1 || out_ack !== 1'b0 || n != 1) begin
            bad++;
            $display("FAIL fresh_ack: got iack=%0b oack=%0b lat=%0d, required 1 0 1", in_ack, out_ack, n);
        end
        total++;
        if (res_cnt != rc0) begin
            bad++;
            $display("FAIL aborted_result: got %0d results after reset, required 0", res_cnt - rc0);
        end
        in_req = 1'b0;
        sb.push_back({DIR_IN, 1'b1, 1'b0});
        cyc();
        fib_done = 1'b1;
        cyc();
        fib_done = 1'b0;
        total++;
        if (res_valid !== 1'b1) begin
            bad++;
            $display("FAIL post_reset_result: got res_valid=%0b, required 1", res_valid);
        end
        cyc();
        cyc();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_out();
        test_back_to_back();
        test_retry();
        test_timeout();
        test_done_at_timeout();
        test_reset_mid_wait();
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL sb_leftover: got %0d pending results, required 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
